serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder built around the existing single-bit full_adder cell.
- Latches two WIDTH-bit operands, feeds one bit pair per clock into the cell, and registers Cout as the next Cin.
- Shifts S into a result register and flags completion with a done pulse.
- Sits directly upstream of the full_adder: it is the sequential driver that supplies A/B/Cin and consumes S/Cout.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when accept condition holds
- a  input  WIDTH  operand A, captured on accept
- b  input  WIDTH  operand B, captured on accept
- busy  output  1  high while state is SHIFT
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result, held until next accept
- cout  output  1  final carry, held until next accept

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state = IDLE; busy = 0, done = 0, sum = 0, cout = 0; internal shift regs, carry flop and bit counter = 0.
- States:
  - IDLE: waiting for start.
  - SHIFT: processing one bit per cycle.
  - DONE: single cycle, done = 1.
- Accept condition: start = 1 while state is IDLE or DONE.
- At the accept edge N:
  - a and b load into operand shift regs.
  - Carry flop clears to 0 (see optional feature).
  - Counter clears to 0; state goes to SHIFT.
- SHIFT, each edge:
  - Operand LSBs drive full_adder A/B; carry flop drives Cin.
  - S shifts into sum MSB (sum shifts right).
  - Cout loads into the carry flop.
  - Operand regs shift right; counter increments.
- Completion:
  - On the edge where counter == WIDTH-1, the last bit is processed, cout takes the final Cout, and state goes to DONE.
  - Latency: done is high in the cycle after edge N+WIDTH. busy is high from edge N to edge N+WIDTH.
- Counter: width $clog2(WIDTH); no wrap is reached because the terminal count is WIDTH-1.
- Boundary conditions:
  - start while in SHIFT is ignored: no queueing, operands unchanged.
  - start held high continuously produces back-to-back operations; one done pulse per operation; no idle cycle is required between DONE and the next SHIFT.
  - Changes on a/b after accept have no effect.
  - sum/cout are undefined-free mid-operation (partial shifts are visible) but are only valid when done = 1 or afterwards in IDLE.
  - rst asserted mid-SHIFT returns immediately to reset values; no done pulse.
- Arithmetic: unsigned; {cout, sum} = a + b modulo 2^(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accept.
  - When sub = 1: b is stored inverted and the carry flop initialises to 1, so sum = a - b mod 2^WIDTH.
  - cout = 1 means no borrow (a >= b).
- Undefined: no sub port; addition only; carry initialises to 0.

Decomposition:
- Package serial_adder_pkg holds:
  - State encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2; state 2'd3 is unreachable and recovers to IDLE.
  - Default WIDTH constant.
- Sub-module: one instance of the existing full_adder (ports A, B, Cin, S, Cout) as the bit-slice datapath. All remaining logic stays in serial_adder.

Test Plan:
- WIDTH = 8, a = 0x00, b = 0x00, start at edge N → done only in the cycle after edge N+8; sum = 0x00, cout = 0; busy high for exactly 8 cycles.
- a = 0xFF, b = 0x01 → sum = 0x00, cout = 1. a = 0xC8, b = 0x64 → sum = 0x2C, cout = 1. a = 0xA5, b = 0x5A → sum = 0xFF, cout = 0.
- Busy-ignore: start with a = 0x10, b = 0x20; pulse start at N+3 with a = 0xFF, b = 0xFF → result is sum = 0x30, cout = 0; exactly one done pulse.
- Back-to-back: start held high with 0x01+0x01 then 0x80+0x80 → done at N+8 (sum = 0x02, cout = 0) then at N+17 (sum = 0x00, cout = 1).
- Reset mid-op: assert rst asynchronously at N+3 → busy, done, sum and cout go to 0 immediately, no done pulse; then 0x03+0x04 → sum = 0x07.
- SERIAL_ADDER_SUB_EN: sub = 1, 0x05-0x03 → sum = 0x02, cout = 1; 0x03-0x05 → sum = 0xFE, cout = 0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: combinational, zero latency, no flow control.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one bit per clock, done pulses WIDTH+1 cycles after accept.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] opb_load_d;
    logic             carry_init_d;

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign opb_load_d   = sub ? ~b : b;
    assign carry_init_d = sub;
`else
    assign opb_load_d   = b;
    assign carry_init_d = 1'b0;
`endif

    full_adder u_fa (
        .A    (opa_q[0]),
        .B    (opb_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= opb_load_d;
                        carry_q <= carry_init_d;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, corner sequences, random ops.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done.
    // lat counts falling edges after the accept edge; done belongs on the 9th.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          output int lat, output int bcnt,
                          output logic [W-1:0] rs, output logic rc);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        rs = sum; rc = cout;
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                input logic ts, input logic [W-1:0] es, input logic ec);
        int lat, bcnt;
        logic [W-1:0] rs;
        logic rc;
        run_op(ta, tb_v, ts, lat, bcnt, rs, rc);
        chk({tag, "_sum"}, 32'(rs), 32'(es));
        chk({tag, "_cout"}, 32'(rc), 32'(ec));
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int dcnt, first_done, second_done;
        logic [W-1:0] got_sum;
        logic got_cout;
        logic [W:0] model;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h03, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0});
`endif
        foreach (vecs[i])
            op_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                         vecs[i].exp_sum, vecs[i].exp_cout);

        // start during SHIFT must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0; got_sum = '0; got_cout = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                got_sum = sum;
                got_cout = cout;
            end
        end
        chk("ignore_done_pulses", 32'(dcnt), 32'd1);
        chk("ignore_sum", 32'(got_sum), 32'h30);
        chk("ignore_cout", 32'(got_cout), 32'd0);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h80; b = 8'h80;
        dcnt = 0; first_done = -1; second_done = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 10) start = 1'b0;
            if (done) begin
                dcnt++;
                if (first_done < 0) begin
                    first_done = k;
                    chk("b2b_sum1", 32'(sum), 32'h02);
                    chk("b2b_cout1", 32'(cout), 32'd0);
                end else if (second_done < 0) begin
                    second_done = k;
                    chk("b2b_sum2", 32'(sum), 32'h00);
                    chk("b2b_cout2", 32'(cout), 32'd1);
                end
            end
        end
        chk("b2b_done_count", 32'(dcnt), 32'd2);
        chk("b2b_first_at", 32'(first_done), 32'd9);
        chk("b2b_second_at", 32'(second_done), 32'd18);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 8'h77; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'd0);
        op_and_check("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

        // random operations against arithmetic reference
        for (int n = 0; n < 30; n++) begin
            logic rsub;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            if (rsub) begin
                model[W-1:0] = ra - rb;
                model[W] = (ra >= rb);
            end else begin
                model = {1'b0, ra} + {1'b0, rb};
            end
            op_and_check($sformatf("rand%0d", n), ra, rb, rsub, model[W-1:0], model[W]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
